// File: rtl/tube_event_reader.sv
// Read side of the tube-word FIFO: pops 16-bit words, checks layer/tube framing and
// reassembles 32 radii into one 256-bit drift-time event with hit mask and hit count.
module tube_event_reader #(
    parameter logic [7:0] NO_HIT    = 8'hFF,
    parameter int         TIMEOUT   = 1024,
    parameter int         ERR_CNT_W = 16
) (
    input  logic                 clk100,
    input  logic                 rst,
    output logic                 rd_en,
    input  logic                 rd_empty,
    input  logic                 rd_valid,
    input  logic [15:0]          rd_data,
    output logic [255:0]         ev_data,
    output logic [31:0]          ev_hit_mask,
    output logic [5:0]           ev_hit_count,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic [ERR_CNT_W-1:0] frame_err_cnt,
    output logic [ERR_CNT_W-1:0] timeout_cnt
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {FETCH, WAIT, CHECK, HOLD} state_t;

    state_t             state_q, state_d;
    logic [4:0]         idx_q;
    logic               in_sync_q;
    logic [15:0]        word_q;
    logic [255:0]       ev_buf_q;
    logic [TMR_W-1:0]   tmr_q;

    logic               word_match, word_is_start, tmo_fire;
    logic [255:0]       full_event;
    logic [31:0]        mask_d;
    logic [5:0]         count_d;

    // Layer/tube tag expected at word index i: groups 3A, 3B, 4A, 4B of eight tubes each.
    function automatic logic [7:0] expected_tag(input logic [4:0] i);
        logic [4:0] layer;
        case (i[4:3])
            2'd0:    layer = 5'b11000;
            2'd1:    layer = 5'b11001;
            2'd2:    layer = 5'b00100;
            default: layer = 5'b00101;
        endcase
        return {layer, i[2:0]};
    endfunction

    assign word_match    = (word_q[15:8] == expected_tag(idx_q));
    assign word_is_start = (word_q[15:8] == expected_tag(5'd0));
    // Timeout only acts in FETCH, so it never collides with a read already in flight.
    assign tmo_fire      = (state_q == FETCH) && (idx_q != 5'd0) && (tmr_q == TMR_W'(TIMEOUT - 1));
    assign rd_en         = (state_q == FETCH) && !rd_empty && !tmo_fire && !rst;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        full_event          = ev_buf_q;
        full_event[255:248] = word_q[7:0];
        mask_d              = '0;
        count_d             = '0;
        for (int k = 0; k < 32; k++) begin
            mask_d[k] = (full_event[8*k +: 8] != NO_HIT);
            count_d   = count_d + 6'(mask_d[k]);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: if (!tmo_fire && !rd_empty) state_d = WAIT;
            WAIT:  state_d = rd_valid ? CHECK : FETCH;
            CHECK: state_d = (in_sync_q && word_match && idx_q == 5'd31) ? HOLD : FETCH;
            HOLD:  if (ev_ready) state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk100) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q       <= FETCH;
            idx_q         <= '0;
            in_sync_q     <= 1'b1;
            word_q        <= '0;
            tmr_q         <= '0;
            // NOTE: the assembly buffer is reset too, so a reset mid-event leaves no stale radii.
            ev_buf_q      <= '0;
            ev_data       <= '0;
            ev_hit_mask   <= '0;
            ev_hit_count  <= '0;
            ev_valid      <= 1'b0;
            frame_err_cnt <= '0;
            timeout_cnt   <= '0;
        end else begin
            state_q <= state_d;

            if (state_q == HOLD || idx_q == 5'd0)
                tmr_q <= '0;
            else if (tmr_q != TMR_W'(TIMEOUT - 1))
                tmr_q <= tmr_q + 1'b1;

            case (state_q)
                FETCH: begin
                    if (tmo_fire) begin
                        if (timeout_cnt != '1) timeout_cnt <= timeout_cnt + 1'b1;
                        ev_buf_q <= '0;
                        idx_q    <= '0;
                    end
                end
                WAIT: begin
                    if (rd_valid) word_q <= rd_data;
                end
                CHECK: begin
                    if (!in_sync_q) begin
                        if (word_is_start) begin
                            in_sync_q      <= 1'b1;
                            ev_buf_q[7:0]  <= word_q[7:0];
                            idx_q          <= 5'd1;
                            tmr_q          <= '0;
                        end
                    end else if (word_match) begin
                        ev_buf_q[8*idx_q +: 8] <= word_q[7:0];
                        tmr_q                  <= '0;
                        if (idx_q == 5'd31) begin
                            ev_data      <= full_event;
                            ev_hit_mask  <= mask_d;
                            ev_hit_count <= count_d;
                            ev_valid     <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        if (frame_err_cnt != '1) frame_err_cnt <= frame_err_cnt + 1'b1;
                        ev_buf_q <= '0;
                        tmr_q    <= '0;
                        if (word_is_start) begin
                            ev_buf_q[7:0] <= word_q[7:0];
                            idx_q         <= 5'd1;
                        end else begin
                            idx_q     <= '0;
                            in_sync_q <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (ev_ready) begin
                        ev_valid <= 1'b0;
                        idx_q    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
